// File: rtl/xgriscv_pkg.sv
// Shared encodings for the xgriscv single-cycle core: RV32I opcodes,
// funct3/funct7 codes, the ALU operation enumeration and a small helper
// that maps funct3 (plus the funct7 "alternate" bit) onto an ALU op.
package xgriscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0, F3_LH   = 3'd1, F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4, F3_LHU  = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH   = 3'd1, F3_SW  = 3'd2;
  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL  = 3'd1, F3_SLT = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3, F3_XOR  = 3'd4, F3_SR  = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6, F3_AND  = 3'd7;

  localparam logic [6:0] F7_STD = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  // alt selects SUB/SRA; the caller only raises it where that is legal.
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imem.sv
// Read-only instruction memory, asynchronous read. Contents are loaded
// from outside by hierarchical access to RAM.
//   waddr : word address (PC[31:2]); wrapped modulo WORDS
//   rdata : instruction word
module imem #(
  parameter int WORDS = 1024
) (
  input  logic [29:0] waddr,
  output logic [31:0] rdata
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0]   RAM [0:WORDS-1];
  logic [AW-1:0] idx;

  assign idx   = AW'(waddr % 30'(WORDS));
  assign rdata = RAM[idx];

endmodule

// File: rtl/xgriscv_sc.sv
// Single-cycle RV32I core: one instruction fetched, decoded, executed,
// memory-accessed and written back per clk. Register file, decoder, ALU
// and data memory live here; instruction memory is the U_imem instance.
//   clk  : rising-edge clock
//   rstn : async active-low reset (PC -> RESET_PC, x1..x31 -> 0)
//   pcW  : PC of the instruction retiring this cycle
module xgriscv_sc
  import xgriscv_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] pcW
);
  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic [31:0] pc_q, pc_d, instr;
  logic [31:0] rf_q   [0:31];
  logic [31:0] dmem_q [0:DMEM_WORDS-1];

  imem #(.WORDS(IMEM_WORDS)) U_imem (.waddr(pc_q[31:2]), .rdata(instr));

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [31:0] rs1_v, rs2_v;
  assign rs1_v = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1];
  assign rs2_v = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2];

  // Decode. Anything not in the 37-instruction set drops every side effect
  // at the end, which turns it into a NOP that falls through to PC+4.
  alu_op_e     alu_op;
  logic [31:0] imm;
  logic        legal, use_imm, src_pc, rd_we, is_ld, is_st, is_br, is_jal, is_jalr;

  always_comb begin
    legal = 1'b0; alu_op = ALU_ADD; imm = imm_i; use_imm = 1'b0; src_pc = 1'b0;
    rd_we = 1'b0; is_ld = 1'b0; is_st = 1'b0; is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    case (opc)
      OP_LUI:    begin legal = 1'b1; imm = imm_u; use_imm = 1'b1; alu_op = ALU_PASSB; rd_we = 1'b1; end
      OP_AUIPC:  begin legal = 1'b1; imm = imm_u; use_imm = 1'b1; src_pc = 1'b1; rd_we = 1'b1; end
      OP_JAL:    begin legal = 1'b1; imm = imm_j; is_jal = 1'b1; rd_we = 1'b1; end
      OP_JALR:   begin legal = (f3 == 3'd0); use_imm = 1'b1; is_jalr = 1'b1; rd_we = 1'b1; end
      OP_BRANCH: begin legal = (f3 != 3'd2) && (f3 != 3'd3); imm = imm_b; is_br = 1'b1; end
      OP_LOAD:   begin
        legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        use_imm = 1'b1; is_ld = 1'b1; rd_we = 1'b1;
      end
      OP_STORE:  begin legal = (f3 <= F3_SW); imm = imm_s; use_imm = 1'b1; is_st = 1'b1; end
      OP_IMM:    begin
        // Only shifts look at funct7; ADDI with imm[10] set is still ADDI.
        use_imm = 1'b1; rd_we = 1'b1;
        alu_op  = alu_dec(f3, (f3 == F3_SR) && f7[5]);
        if (f3 == F3_SLL)     legal = (f7 == F7_STD);
        else if (f3 == F3_SR) legal = (f7 == F7_STD) || (f7 == F7_ALT);
        else                  legal = 1'b1;
      end
      OP_OP:     begin
        rd_we  = 1'b1;
        alu_op = alu_dec(f3, f7[5]);
        legal  = (f7 == F7_STD) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      end
      default: ;
    endcase
    if (!legal) begin
      rd_we = 1'b0; is_st = 1'b0; is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; is_ld = 1'b0;
    end
  end

  // ALU; also forms the load/store address and the JALR target.
  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  shamt;
  assign alu_a = src_pc ? pc_q : rs1_v;
  assign alu_b = use_imm ? imm : rs2_v;
  assign shamt = alu_b[4:0];

  always_comb begin
    case (alu_op)
      ALU_SUB:   alu_res = alu_a - alu_b;
      ALU_SLL:   alu_res = alu_a << shamt;
      ALU_SLT:   alu_res = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_res = {31'h0, alu_a < alu_b};
      ALU_XOR:   alu_res = alu_a ^ alu_b;
      ALU_SRL:   alu_res = alu_a >> shamt;
      ALU_SRA:   alu_res = $signed(alu_a) >>> shamt;
      ALU_OR:    alu_res = alu_a | alu_b;
      ALU_AND:   alu_res = alu_a & alu_b;
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = alu_a + alu_b;
    endcase
  end

  logic taken;
  always_comb begin
    case (f3)
      F3_BEQ:  taken = (rs1_v == rs2_v);
      F3_BNE:  taken = (rs1_v != rs2_v);
      F3_BLT:  taken = ($signed(rs1_v) < $signed(rs2_v));
      F3_BGE:  taken = ($signed(rs1_v) >= $signed(rs2_v));
      F3_BLTU: taken = (rs1_v < rs2_v);
      F3_BGEU: taken = (rs1_v >= rs2_v);
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (is_jal || (is_br && taken)) pc_d = pc_q + imm;
    else if (is_jalr)               pc_d = {alu_res[31:1], 1'b0};
  end

  // Data memory: little-endian, combinational read, byte-lane writes.
  logic [DAW-1:0] didx;
  logic [31:0]    dmem_rd, st_wdata, ld_data, wb_d;
  logic [7:0]     ld_b;
  logic [15:0]    ld_h;
  logic [3:0]     st_be;
  assign didx    = DAW'(alu_res[31:2] % 30'(DMEM_WORDS));
  assign dmem_rd = dmem_q[didx];
  assign ld_h    = alu_res[1] ? dmem_rd[31:16] : dmem_rd[15:0];

  always_comb begin
    case (alu_res[1:0])
      2'd0:    ld_b = dmem_rd[7:0];
      2'd1:    ld_b = dmem_rd[15:8];
      2'd2:    ld_b = dmem_rd[23:16];
      default: ld_b = dmem_rd[31:24];
    endcase
    case (f3)
      F3_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
      F3_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
      F3_LBU:  ld_data = {24'h0, ld_b};
      F3_LHU:  ld_data = {16'h0, ld_h};
      default: ld_data = dmem_rd;
    endcase
    case (f3)
      F3_SB:   begin st_wdata = {4{rs2_v[7:0]}};  st_be = 4'b0001 << alu_res[1:0]; end
      F3_SH:   begin st_wdata = {2{rs2_v[15:0]}}; st_be = alu_res[1] ? 4'b1100 : 4'b0011; end
      default: begin st_wdata = rs2_v;            st_be = 4'b1111; end
    endcase
    if (is_jal || is_jalr) wb_d = pc_plus4;
    else if (is_ld)        wb_d = ld_data;
    else                   wb_d = alu_res;
  end

  // No reset on the array: contents survive rstn, only writes are held off.
  always_ff @(posedge clk) begin
    if (rstn && is_st) begin
      for (int i = 0; i < 4; i++)
        if (st_be[i]) dmem_q[didx][8*i +: 8] <= st_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (rd_we && (rd != 5'd0)) begin
      rf_q[rd] <= wb_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pcW = pc_q;

endmodule

// File: tb/tb_xgriscv_sc.sv
module tb_xgriscv_sc;
  localparam int IMEM = 1024;
  localparam int DMEM = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] pcW;

  xgriscv_sc #(.IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .pcW(pcW));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ISA-level reference state
  logic [31:0] m_imem [IMEM];
  logic [31:0] m_dmem [DMEM];
  logic [31:0] m_x    [32];
  logic [31:0] m_pc;
  logic [31:0] prog   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  // Register/register or register/immediate arithmetic; returns 0 for
  // encodings outside the instruction set.
  function automatic bit arith(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                               input logic [31:0] b, input bit imm, output logic [31:0] r);
    int sh = int'(b % 32);
    bit ok = 1;
    bit std = imm || (f7 == 7'h00);
    r = 0;
    case (f3)
      3'd0: if (std) r = a + b; else if (f7 == 7'h20) r = a - b; else ok = 0;
      3'd1: if (f7 == 7'h00) r = a << sh; else ok = 0;
      3'd2: if (std) r = ($signed(a) < $signed(b)) ? 1 : 0; else ok = 0;
      3'd3: if (std) r = (a < b) ? 1 : 0; else ok = 0;
      3'd4: if (std) r = a ^ b; else ok = 0;
      3'd5: if (f7 == 7'h00) r = a >> sh; else if (f7 == 7'h20) r = $signed(a) >>> sh; else ok = 0;
      3'd6: if (std) r = a | b; else ok = 0;
      default: if (std) r = a & b; else ok = 0;
    endcase
    return ok;
  endfunction

  task automatic iss_step();
    logic [31:0] ins, a, b, ii, is, ib, ij, npc, wv, addr, word;
    logic [7:0]  by;
    logic [15:0] hw;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int idx, sh;
    bit wr;
    ins = m_imem[int'((m_pc >> 2) % IMEM)];
    rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a = m_x[rs1]; b = m_x[rs2];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 4; wr = 0; wv = 0;
    case (ins[6:0])
      7'h37: begin wr = 1; wv = {ins[31:12], 12'h0}; end
      7'h17: begin wr = 1; wv = m_pc + {ins[31:12], 12'h0}; end
      7'h6f: begin wr = 1; wv = m_pc + 4; npc = m_pc + ij; end
      7'h67: if (f3 == 0) begin wr = 1; wv = m_pc + 4; npc = (a + ii) & ~32'd1; end
      7'h63: case (f3)
        3'd0: if (a == b) npc = m_pc + ib;
        3'd1: if (a != b) npc = m_pc + ib;
        3'd4: if ($signed(a) <  $signed(b)) npc = m_pc + ib;
        3'd5: if ($signed(a) >= $signed(b)) npc = m_pc + ib;
        3'd6: if (a <  b) npc = m_pc + ib;
        3'd7: if (a >= b) npc = m_pc + ib;
        default: ;
      endcase
      7'h03: begin
        addr = a + ii;
        word = m_dmem[int'((addr >> 2) % DMEM)];
        by = 8'(word >> (8 * (addr % 4)));
        hw = 16'(word >> (16 * ((addr >> 1) % 2)));
        wr = 1;
        case (f3)
          3'd0: wv = {{24{by[7]}}, by};
          3'd1: wv = {{16{hw[15]}}, hw};
          3'd2: wv = word;
          3'd4: wv = {24'h0, by};
          3'd5: wv = {16'h0, hw};
          default: wr = 0;
        endcase
      end
      7'h23: begin
        addr = a + is;
        idx = int'((addr >> 2) % DMEM);
        word = m_dmem[idx];
        case (f3)
          3'd0: begin sh = int'(8 * (addr % 4));
                  word = (word & ~(32'hFF << sh)) | ((b & 32'hFF) << sh); end
          3'd1: begin sh = int'(16 * ((addr >> 1) % 2));
                  word = (word & ~(32'hFFFF << sh)) | ((b & 32'hFFFF) << sh); end
          3'd2: word = b;
          default: ;
        endcase
        if (f3 <= 2) m_dmem[idx] = word;
      end
      7'h13: wr = arith(f3, f7, a, ii, 1, wv);
      7'h33: wr = arith(f3, f7, a, b, 0, wv);
      default: ;
    endcase
    if (wr && rd != 0) m_x[rd] = wv;
    m_pc = npc;
  endtask

  // Compare retiring PC with the model, advance the model, clock once.
  task automatic step(input string tag);
    chk(tag, pcW, m_pc);
    iss_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_prog();
    for (int i = 0; i < IMEM; i++) begin
      m_imem[i] = (i < prog.size()) ? prog[i] : NOP;
      dut.U_imem.RAM[i] = m_imem[i];
    end
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    m_pc = 0;
    foreach (m_x[i]) m_x[i] = 0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("rst_pc", pcW, 32'h0);
    end
    rstn = 1'b1;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_x%0d", tag, i), dut.rf_q[i], m_x[i]);
  endtask

  function automatic logic [31:0] rand_ins(int k, int rd, int r1, int r2, int pc, int off);
    int mi = 256 + $urandom_range(31, 0);
    int f3 = 0, f7 = 0;
    if (k == 0) return enc_u(int'($urandom), rd, 7'h37);
    if (k == 1) return enc_u(int'($urandom), rd, 7'h17);
    if (k == 2) return enc_j(off, rd);
    if (k == 3) return enc_i(pc + off, 0, 0, rd, 7'h67);
    if (k < 10) begin
      case (k) 4: f3 = 0; 5: f3 = 1; 6: f3 = 4; 7: f3 = 5; 8: f3 = 6; default: f3 = 7; endcase
      return enc_b(off, r2, r1, f3);
    end
    if (k < 15) return enc_i(mi, 0, (k < 13) ? k - 10 : k - 9, rd, 7'h03);
    if (k < 18) return enc_s(mi, r2, 0, k - 15);
    if (k < 24) begin
      case (k) 18: f3 = 0; 19: f3 = 2; 20: f3 = 3; 21: f3 = 4; 22: f3 = 6; default: f3 = 7; endcase
      return enc_i(int'($urandom), r1, f3, rd, 7'h13);
    end
    if (k == 24) return enc_i(int'($urandom_range(31, 0)), r1, 1, rd, 7'h13);
    if (k == 25) return enc_i(int'($urandom_range(31, 0)), r1, 5, rd, 7'h13);
    if (k == 26) return enc_i(1024 + int'($urandom_range(31, 0)), r1, 5, rd, 7'h13);
    case (k)
      27: f3 = 0; 28: begin f3 = 0; f7 = 32; end 29: f3 = 1; 30: f3 = 2; 31: f3 = 3;
      32: f3 = 4; 33: f3 = 5; 34: begin f3 = 5; f7 = 32; end 35: f3 = 6; default: f3 = 7;
    endcase
    return enc_r(f7, r2, r1, f3, rd, 7'h33);
  endfunction

  // Seed x1..x7, clear the data window 0x100..0x11F, then one of each of
  // the 37 instructions in shuffled order, then a self-loop halt.
  task automatic gen_rand(output logic [31:0] halt);
    int kinds [37];
    int j, t;
    prog.delete();
    for (int r = 1; r < 8; r++) begin
      prog.push_back(enc_u(int'($urandom), r, 7'h37));
      prog.push_back(enc_i(int'($urandom), r, 0, r, 7'h13));
    end
    for (int w = 0; w < 8; w++) prog.push_back(enc_s(256 + 4 * w, 0, 0, 2));
    for (int k = 0; k < 37; k++) kinds[k] = k;
    for (int k = 36; k > 0; k--) begin
      j = int'($urandom_range(k, 0)); t = kinds[k]; kinds[k] = kinds[j]; kinds[j] = t;
    end
    for (int k = 0; k < 37; k++)
      prog.push_back(rand_ins(kinds[k], int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                              int'($urandom_range(7, 0)), 4 * prog.size(),
                              ($urandom_range(1, 0) == 1) ? 8 : 4));
    prog.push_back(NOP);
    halt = 32'(4 * prog.size());
    prog.push_back(enc_j(0, 0));
  endtask

  initial begin
    logic [31:0] halt;
    logic [31:0] ctl_exp [13];
    int n;
    foreach (m_dmem[i]) m_dmem[i] = 0;
    @(negedge clk);

    // ALU
    prog = {enc_i(-1, 0, 0, 1, 7'h13), enc_i(28, 1, 5, 2, 7'h13),
            enc_i(1024 + 28, 1, 5, 3, 7'h13), enc_r(0, 1, 0, 3, 4, 7'h33)};
    load_prog();
    do_reset();
    repeat (5) step("alu_pc");
    chk("alu_x1", dut.rf_q[1], 32'hFFFF_FFFF);
    chk("alu_x2", dut.rf_q[2], 32'h0000_000F);
    chk("alu_x3", dut.rf_q[3], 32'hFFFF_FFFF);
    chk("alu_x4", dut.rf_q[4], 32'h0000_0001);
    chk_regs("alu");

    // Reset: registers cleared, PC sequence 0,4,8 after release
    do_reset();
    chk("rst_x1", dut.rf_q[1], 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("rst_seq", pcW, 32'(4 * k));
      step("rst_pc_model");
    end

    // Memory
    prog = {enc_i(32'h80, 0, 0, 5, 7'h13), enc_u(32'h12345, 6, 7'h37), enc_i(32'h678, 6, 0, 6, 7'h13),
            enc_s(0, 6, 5, 2), enc_i(1, 5, 0, 7, 7'h03), enc_i(2, 5, 5, 8, 7'h03),
            enc_s(3, 0, 5, 0), enc_i(0, 5, 2, 9, 7'h03)};
    load_prog();
    do_reset();
    repeat (9) step("mem_pc");
    chk("mem_lb",  dut.rf_q[7], 32'h0000_0056);
    chk("mem_lhu", dut.rf_q[8], 32'h0000_1234);
    chk("mem_lw",  dut.rf_q[9], 32'h0034_5678);
    chk("mem_word", dut.dmem_q[32], m_dmem[32]);
    chk_regs("mem");

    // Control flow
    prog = {NOP, NOP, NOP, NOP, enc_b(8, 0, 0, 0), NOP, NOP, NOP,
            enc_j(12, 1), NOP, NOP, enc_i(0, 1, 0, 0, 7'h67)};
    ctl_exp = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C,
                32'h20, 32'h2C, 32'h24, 32'h28, 32'h2C, 32'h24};
    load_prog();
    do_reset();
    for (int k = 0; k < 13; k++) begin
      chk("ctl_seq", pcW, ctl_exp[k]);
      step("ctl_pc_model");
    end
    chk("ctl_x1", dut.rf_q[1], 32'h24);

    // Edge cases: x0 write, undefined encodings (incl. illegal SLLI and store)
    prog = {enc_i(7, 0, 0, 7, 7'h13), enc_i(9, 0, 0, 6, 7'h13), enc_i(5, 0, 0, 0, 7'h13),
            enc_r(0, 0, 0, 0, 6, 7'h33), 32'hFFFF_FFFF, enc_i(1024 + 3, 7, 1, 6, 7'h13),
            enc_s(32'h80, 7, 0, 3)};
    load_prog();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      chk("edge_seq", pcW, 32'(4 * k));
      step("edge_pc_model");
    end
    chk("edge_x0", dut.rf_q[0], 32'h0);
    chk("edge_x6", dut.rf_q[6], 32'h0);
    chk("edge_mem", dut.dmem_q[32], 32'h0034_5678);
    chk_regs("edge");

    // Random programs covering all 37 instructions
    for (int it = 0; it < 3; it++) begin
      gen_rand(halt);
      load_prog();
      do_reset();
      n = 0;
      while (pcW !== halt && n < 300) begin
        step("rnd_pc");
        n++;
      end
      chk("rnd_halt", pcW, halt);
      chk_regs("rnd");
      for (int w = 64; w < 72; w++) chk($sformatf("rnd_mem%0d", w), dut.dmem_q[w], m_dmem[w]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xgriscv_sc.md
XGRISCV_SC -- requirements
Module: xgriscv_sc

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 1024, giving the instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 1024, giving the data memory depth in 32-bit words.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value after reset.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- pcW  output  32  PC of the instruction completing (retiring) in the current cycle.

Function
REQ-005 SHALL be a single-cycle RV32I core: fetch, decode, execute, memory access and writeback of one instruction per clk cycle.
REQ-006 SHALL implement exactly 37 instructions: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-007 SHALL treat any other encoding as a NOP: no register or memory write, next PC = PC+4.
REQ-008 SHALL fetch the instruction combinationally from imem word index PC[31:2] modulo IMEM_WORDS.
REQ-009 SHALL compute next PC as: branch taken or JAL -> PC+imm; JALR -> (rs1+imm) with bit 0 cleared; otherwise PC+4, all modulo 2^32.
REQ-010 SHALL write PC+4 to rd for JAL/JALR, including when rd equals rs1 (old rs1 is used for the target).
REQ-011 SHALL use a 32x32 register file with two combinational reads and one synchronous write; x0 reads 0 and writes to it are discarded.
REQ-012 SHALL mask shift amounts to 5 bits; SRA/SRAI are arithmetic; SLT/SLTI are signed; SLTU/SLTIU/BLTU/BGEU are unsigned; overflow wraps.
REQ-013 SHALL use a byte-addressed little-endian data memory, word index addr[31:2] modulo DMEM_WORDS, with a combinational read and a write on the clk rising edge.
REQ-014 SHALL write only the addressed lanes for SB/SH (addr[1:0]; addr[1] for halves); LB/LH sign-extend, LBU/LHU zero-extend; misaligned low bits of LW/SW are ignored.
REQ-015 SHALL drive pcW = current PC, combinationally.

Reset
REQ-016 SHALL, while rstn is low, force PC = RESET_PC, clear all 31 writable registers to 0, and suppress all register and memory writes.
REQ-017 SHALL retain imem and dmem contents across reset.
REQ-018 SHALL fetch the first instruction at RESET_PC in the first rising edge after rstn deasserts.

Structure
REQ-019 SHALL put opcode constants (7'b0110111 LUI ... 7'b0110011 OP), funct3/funct7 codes and the ALU-op enumeration in a shared package xgriscv_pkg.
REQ-020 SHALL instantiate one sub-module imem, instance name U_imem, holding array RAM[0:IMEM_WORDS-1] of 32 bits, loadable by hierarchical $readmemh, read-only with an asynchronous read.
REQ-021 SHALL keep the register file, ALU, decoder and dmem inline in xgriscv_sc.

Verification
REQ-022 Reset: hold rstn low for 2 cycles with an arbitrary program, then release -> pcW = 0 during reset, then 0, 4, 8 on successive cycles.
REQ-023 ALU: ADDI x1,x0,-1; SRLI x2,x1,28; SRAI x3,x1,28; SLTU x4,x0,x1 -> x1 = FFFFFFFF, x2 = 0000000F, x3 = FFFFFFFF, x4 = 1.
REQ-024 Memory: x5 = 0x80; SW of 0x12345678 to 0(x5); LB 1(x5); LHU 2(x5); SB x0,3(x5); LW 0(x5) -> 00000056, 00001234, 00345678.
REQ-025 Control: BEQ x0,x0,+8 at 0x10 -> pcW goes 0x10 then 0x18; JAL x1,+12 at 0x20 -> x1 = 0x24, next pcW 0x2C; JALR x0,0(x1) -> pcW 0x24.
REQ-026 Edge cases: ADDI x0,x0,5 then ADD x6,x0,x0 -> x6 = 0; an undefined opcode 0xFFFFFFFF -> no state change, pcW advances by 4.
REQ-027 End of program: load a 37-instruction program covering all opcodes, compare the register/dmem dump against a golden model, and stop when pcW equals the final instruction address.
